// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - LEGv8 controller opcodes, ALU selects, state encoding and op-class decode
package legv8_pkg;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_BR   = 11'b11010110000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;

    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;
    localparam logic [4:0] XZR    = 5'd31;

    typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

    typedef enum logic [2:0] {
        OP_ILLEGAL, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_LDUR, OP_STUR, OP_BR
    } op_t;

    typedef struct packed {
        logic        w;
        logic        en_alu;
        logic        en_b;
        logic        en_addr;
        logic        k_sel;
        logic        pc_sel;
        logic        c0;
        logic        cs;
        logic        we;
        logic        oe;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic [4:0]  fs;
        logic [63:0] k;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = ctrl_word_t'({10'b0, XZR, XZR, XZR, 5'b0, 64'b0});

    function automatic op_t legv8_decode(input logic [31:0] ir);
        if (ir[31:21] == OPC_ADD)       return OP_ADD;
        else if (ir[31:21] == OPC_SUB)  return OP_SUB;
        else if (ir[31:21] == OPC_LDUR) return OP_LDUR;
        else if (ir[31:21] == OPC_STUR) return OP_STUR;
        else if (ir[31:21] == OPC_BR)   return OP_BR;
        else if (ir[31:22] == OPC_ADDI) return OP_ADDI;
        else if (ir[31:22] == OPC_SUBI) return OP_SUBI;
        else                            return OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/legv8_decoder.sv
// rtl/legv8_decoder.sv - combinational field/immediate decode of one LEGv8 instruction
module legv8_decoder
    import legv8_pkg::*;
(
    input  logic [31:0] ir_i,
    output op_t         op_o,
    output logic [4:0]  sa_o,
    output logic [4:0]  sb_o,
    output logic [4:0]  da_o,
    output logic [4:0]  fs_o,
    output logic        c0_o,
    output logic [63:0] k_o,
    output logic        legal_o
);

    assign op_o    = legv8_decode(ir_i);
    assign legal_o = (op_o != OP_ILLEGAL);

    // Unused register ports stay parked on XZR so the idle word is unchanged.
    always_comb begin
        sa_o = ir_i[9:5];
        sb_o = XZR;
        da_o = XZR;
        fs_o = 5'b0;
        c0_o = 1'b0;
        k_o  = 64'b0;
        case (op_o)
            OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
                sb_o = ir_i[20:16];
                da_o = ir_i[4:0];
                c0_o = (op_o == OP_SUB) || (op_o == OP_SUBI);
                fs_o = c0_o ? FS_SUB : FS_ADD;
                if (op_o == OP_ADDI || op_o == OP_SUBI)
                    k_o = {52'b0, ir_i[21:10]};
            end
            OP_LDUR: begin
                da_o = ir_i[4:0];
                fs_o = FS_ADD;
                k_o  = {{55{ir_i[20]}}, ir_i[20:12]};
            end
            OP_STUR: begin
                sb_o = ir_i[4:0];
                fs_o = FS_ADD;
                k_o  = {{55{ir_i[20]}}, ir_i[20:12]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/legv8_control_unit.sv
// rtl/legv8_control_unit.sv - multi-cycle LEGv8 controller driving the ram_datapath control word
module legv8_control_unit
    import legv8_pkg::*;
#(
    parameter int MEM_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        illegal,
    output logic        pc_inc,
    output logic        W,
    output logic        EN_ALU,
    output logic        EN_B,
    output logic        EN_ADDR,
    output logic        K_SEL,
    output logic        PC_SEL,
    output logic        C0,
    output logic        CS,
    output logic        WE,
    output logic        OE,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic [4:0]  FS,
    output logic [63:0] K
);

    localparam logic [1:0] MCNT_LAST = 2'(MEM_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] mcnt_q, mcnt_d;
    logic [31:0] ir_q, ir_d;
    ctrl_word_t word_q, word_d;
    logic       ready_q, ready_d;
    logic       illegal_q, illegal_d;
    logic       pc_inc_q, pc_inc_d;
    logic       accept;

    op_t         dec_op;
    logic [4:0]  dec_sa, dec_sb, dec_da, dec_fs;
    logic        dec_c0, dec_legal;
    logic [63:0] dec_k;

    assign accept = (state_q == FETCH) && instr_valid && ready_q;
    assign ir_d   = accept ? instr : ir_q;

    // Decoding the next-cycle IR lets the word be registered alongside the state.
    legv8_decoder u_decoder (
        .ir_i    (ir_d),
        .op_o    (dec_op),
        .sa_o    (dec_sa),
        .sb_o    (dec_sb),
        .da_o    (dec_da),
        .fs_o    (dec_fs),
        .c0_o    (dec_c0),
        .k_o     (dec_k),
        .legal_o (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        mcnt_d    = mcnt_q;
        illegal_d = 1'b0;
        pc_inc_d  = 1'b0;
        word_d    = CTRL_IDLE;
        case (state_q)
            FETCH: begin
                if (accept) begin
                    if (!dec_legal) begin
                        illegal_d = 1'b1;
                    end else if (dec_op == OP_LDUR || dec_op == OP_STUR) begin
                        state_d = MEM;
                        mcnt_d  = 2'd0;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: state_d = FETCH;
            MEM: begin
                if (mcnt_q == MCNT_LAST) state_d = FETCH;
                else                     mcnt_d  = mcnt_q + 2'd1;
            end
            default: state_d = FETCH;
        endcase

        if (state_d == EXEC) begin
            word_d.sa = dec_sa;
            if (dec_op == OP_BR) begin
                word_d.pc_sel = 1'b1;
            end else begin
                word_d.sb     = dec_sb;
                word_d.da     = dec_da;
                word_d.fs     = dec_fs;
                word_d.c0     = dec_c0;
                word_d.k      = dec_k;
                word_d.k_sel  = (dec_op == OP_ADDI) || (dec_op == OP_SUBI);
                word_d.en_alu = 1'b1;
                word_d.w      = (dec_da != XZR);
                pc_inc_d      = 1'b1;
            end
        end else if (state_d == MEM) begin
            word_d.sa      = dec_sa;
            word_d.sb      = dec_sb;
            word_d.da      = dec_da;
            word_d.fs      = dec_fs;
            word_d.k       = dec_k;
            word_d.k_sel   = 1'b1;
            word_d.en_addr = 1'b1;
            word_d.cs      = 1'b1;
            pc_inc_d       = (mcnt_d == MCNT_LAST);
            if (dec_op == OP_LDUR) begin
                word_d.oe = 1'b1;
                word_d.w  = (mcnt_d == MCNT_LAST) && (dec_da != XZR);
            end else begin
                word_d.en_b = 1'b1;
                word_d.we   = 1'b1;
            end
        end

        ready_d = (state_d == FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            mcnt_q    <= 2'd0;
            ir_q      <= 32'b0;
            word_q    <= CTRL_IDLE;
            ready_q   <= 1'b0;
            illegal_q <= 1'b0;
            pc_inc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcnt_q    <= mcnt_d;
            ir_q      <= ir_d;
            word_q    <= word_d;
            ready_q   <= ready_d;
            illegal_q <= illegal_d;
            pc_inc_q  <= pc_inc_d;
        end
    end

    assign instr_ready = ready_q;
    assign illegal     = illegal_q;
    assign pc_inc      = pc_inc_q;
    assign W           = word_q.w;
    assign EN_ALU      = word_q.en_alu;
    assign EN_B        = word_q.en_b;
    assign EN_ADDR     = word_q.en_addr;
    assign K_SEL       = word_q.k_sel;
    assign PC_SEL      = word_q.pc_sel;
    assign C0          = word_q.c0;
    assign CS          = word_q.cs;
    assign WE          = word_q.we;
    assign OE          = word_q.oe;
    assign SA          = word_q.sa;
    assign SB          = word_q.sb;
    assign DA          = word_q.da;
    assign FS          = word_q.fs;
    assign K           = word_q.k;

endmodule

// File: tb/tb_legv8_control_unit.sv
// tb/tb_legv8_control_unit.sv - directed self-checking bench for legv8_control_unit
module tb_legv8_control_unit;

    localparam logic [4:0] T_FS_ADD = 5'b01000;
    localparam logic [4:0] T_FS_SUB = 5'b01010;
    // control bit order: W EN_ALU EN_B EN_ADDR K_SEL PC_SEL C0 CS WE OE
    localparam logic [9:0] C_NONE = 10'b0000000000;
    localparam logic [9:0] C_ADD  = 10'b1100000000;
    localparam logic [9:0] C_SUB  = 10'b1100001000;
    localparam logic [9:0] C_ADDI = 10'b1100100000;
    localparam logic [9:0] C_SUBI = 10'b1100101000;
    localparam logic [9:0] C_ALU0 = 10'b0100000000;
    localparam logic [9:0] C_STUR = 10'b0011100110;
    localparam logic [9:0] C_LD1  = 10'b0001100101;
    localparam logic [9:0] C_LD2  = 10'b1001100101;
    localparam logic [9:0] C_BR   = 10'b0000010000;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready, illegal, pc_inc;
    logic        W, EN_ALU, EN_B, EN_ADDR, K_SEL, PC_SEL, C0, CS, WE, OE;
    logic [4:0]  SA, SB, DA, FS;
    logic [63:0] K;
    logic [96:0] obs;
    int          checks = 0;
    int          errors = 0;

    legv8_control_unit #(.MEM_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .illegal(illegal), .pc_inc(pc_inc),
        .W(W), .EN_ALU(EN_ALU), .EN_B(EN_B), .EN_ADDR(EN_ADDR), .K_SEL(K_SEL),
        .PC_SEL(PC_SEL), .C0(C0), .CS(CS), .WE(WE), .OE(OE),
        .SA(SA), .SB(SB), .DA(DA), .FS(FS), .K(K)
    );

    assign obs = {instr_ready, illegal, pc_inc, W, EN_ALU, EN_B, EN_ADDR, K_SEL,
                  PC_SEL, C0, CS, WE, OE, SA, SB, DA, FS, K};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // status = {instr_ready, illegal, pc_inc}
    function automatic logic [96:0] ew(input logic [2:0] st, input logic [9:0] ctl,
                                       input logic [4:0] sa, input logic [4:0] sb,
                                       input logic [4:0] da, input logic [4:0] fs,
                                       input logic [63:0] k);
        return {st, ctl, sa, sb, da, fs, k};
    endfunction

    task automatic issue(input logic [31:0] w);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout instr_ready=%b want 1", instr_ready);
        end
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== ew(3'b000, C_NONE, 31, 31, 31, 0, 0)) begin
            errors++;
            $display("FAIL reset_idle got %h want %h", obs, ew(3'b000, C_NONE, 31, 31, 31, 0, 0));
        end
        @(negedge clk);
        checks++;
        if (obs !== ew(3'b100, C_NONE, 31, 31, 31, 0, 0)) begin
            errors++;
            $display("FAIL reset_ready got %h want %h", obs, ew(3'b100, C_NONE, 31, 31, 31, 0, 0));
        end
    endtask

    task automatic test_alu;
        logic [31:0] ins [0:3];
        logic [96:0] exp [0:3];
        ins[0] = 32'h913C03E0;
        exp[0] = ew(3'b001, C_ADDI, 31, 28, 0, T_FS_ADD, 64'hF00);
        ins[1] = 32'hCB020024;
        exp[1] = ew(3'b001, C_SUB, 1, 2, 4, T_FS_SUB, 0);
        ins[2] = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd31};
        exp[2] = ew(3'b001, C_ALU0, 1, 2, 31, T_FS_ADD, 0);
        ins[3] = {10'b1101000100, 12'd1, 5'd9, 5'd9};
        exp[3] = ew(3'b001, C_SUBI, 9, 0, 9, T_FS_SUB, 64'd1);
        for (int i = 0; i < 4; i++) begin
            issue(ins[i]);
            @(negedge clk);
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL alu_exec[%0d] got %h want %h", i, obs, exp[i]);
            end
            @(negedge clk);
            checks++;
            if (obs !== ew(3'b100, C_NONE, 31, 31, 31, 0, 0)) begin
                errors++;
                $display("FAIL alu_after[%0d] got %h want %h", i, obs, ew(3'b100, C_NONE, 31, 31, 31, 0, 0));
            end
        end
    endtask

    task automatic test_mem;
        logic [31:0] ins [0:2];
        logic [96:0] exp [0:2][0:2];
        ins[0] = 32'hF8000002;
        exp[0][0] = ew(3'b000, C_STUR, 0, 2, 31, T_FS_ADD, 0);
        exp[0][1] = ew(3'b001, C_STUR, 0, 2, 31, T_FS_ADD, 0);
        ins[1] = 32'hF8400006;
        exp[1][0] = ew(3'b000, C_LD1, 0, 31, 6, T_FS_ADD, 0);
        exp[1][1] = ew(3'b001, C_LD2, 0, 31, 6, T_FS_ADD, 0);
        ins[2] = {11'b11111000010, 9'h1F8, 2'b00, 5'd3, 5'd5};
        exp[2][0] = ew(3'b000, C_LD1, 3, 31, 5, T_FS_ADD, 64'hFFFF_FFFF_FFFF_FFF8);
        exp[2][1] = ew(3'b001, C_LD2, 3, 31, 5, T_FS_ADD, 64'hFFFF_FFFF_FFFF_FFF8);
        for (int i = 0; i < 3; i++) begin
            exp[i][2] = ew(3'b100, C_NONE, 31, 31, 31, 0, 0);
            issue(ins[i]);
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                checks++;
                if (obs !== exp[i][j]) begin
                    errors++;
                    $display("FAIL mem[%0d] cycle %0d got %h want %h", i, j, obs, exp[i][j]);
                end
            end
        end
    endtask

    task automatic test_br;
        issue(32'hD61F00C0);
        @(negedge clk);
        checks++;
        if (obs !== ew(3'b000, C_BR, 6, 31, 31, 0, 0)) begin
            errors++;
            $display("FAIL br_exec got %h want %h", obs, ew(3'b000, C_BR, 6, 31, 31, 0, 0));
        end
        @(negedge clk);
        checks++;
        if (obs !== ew(3'b100, C_NONE, 31, 31, 31, 0, 0)) begin
            errors++;
            $display("FAIL br_after got %h want %h", obs, ew(3'b100, C_NONE, 31, 31, 31, 0, 0));
        end
    endtask

    task automatic test_illegal;
        logic [31:0] ins [0:1];
        ins[0] = 32'h00000000;
        ins[1] = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            issue(ins[i]);
            @(negedge clk);
            checks++;
            if (obs !== ew(3'b110, C_NONE, 31, 31, 31, 0, 0)) begin
                errors++;
                $display("FAIL illegal_pulse[%0d] got %h want %h", i, obs, ew(3'b110, C_NONE, 31, 31, 31, 0, 0));
            end
            @(negedge clk);
            checks++;
            if (obs !== ew(3'b100, C_NONE, 31, 31, 31, 0, 0)) begin
                errors++;
                $display("FAIL illegal_after[%0d] got %h want %h", i, obs, ew(3'b100, C_NONE, 31, 31, 31, 0, 0));
            end
        end
    endtask

    task automatic test_back_to_back;
        while (!instr_ready) @(negedge clk);
        instr       = {11'b10001011000, 5'd2, 6'd0, 5'd1, 5'd7};
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr = {11'b11001011000, 5'd4, 6'd0, 5'd3, 5'd8};
        @(negedge clk);
        checks++;
        if (obs !== ew(3'b001, C_ADD, 1, 2, 7, T_FS_ADD, 0)) begin
            errors++;
            $display("FAIL b2b_first got %h want %h", obs, ew(3'b001, C_ADD, 1, 2, 7, T_FS_ADD, 0));
        end
        @(negedge clk);
        checks++;
        if (obs !== ew(3'b100, C_NONE, 31, 31, 31, 0, 0)) begin
            errors++;
            $display("FAIL b2b_fetch got %h want %h", obs, ew(3'b100, C_NONE, 31, 31, 31, 0, 0));
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== ew(3'b001, C_SUB, 3, 4, 8, T_FS_SUB, 0)) begin
            errors++;
            $display("FAIL b2b_second got %h want %h", obs, ew(3'b001, C_SUB, 3, 4, 8, T_FS_SUB, 0));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        issue(32'hF8400006);
        @(negedge clk);
        checks++;
        if (obs !== ew(3'b000, C_LD1, 0, 31, 6, T_FS_ADD, 0)) begin
            errors++;
            $display("FAIL rst_mid_mem got %h want %h", obs, ew(3'b000, C_LD1, 0, 31, 6, T_FS_ADD, 0));
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== ew(3'b000, C_NONE, 31, 31, 31, 0, 0)) begin
            errors++;
            $display("FAIL rst_mid_idle got %h want %h", obs, ew(3'b000, C_NONE, 31, 31, 31, 0, 0));
        end
        @(negedge clk);
        checks++;
        if (obs !== ew(3'b100, C_NONE, 31, 31, 31, 0, 0)) begin
            errors++;
            $display("FAIL rst_mid_fetch got %h want %h", obs, ew(3'b100, C_NONE, 31, 31, 31, 0, 0));
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr       = 32'b0;
        instr_valid = 1'b0;
        test_reset;
        test_alu;
        test_mem;
        test_br;
        test_illegal;
        test_back_to_back;
        test_reset_mid_op;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
